branch_predict_resolve: RTL and testbench

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

---
 rtl/branch_predict_resolve_pkg.sv | 25 ++
 rtl/branch_compare.sv | 29 ++
 rtl/branch_predict_resolve.sv | 91 +++++++++
 tb/tb_branch_predict_resolve.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// rtl/branch_predict_resolve_pkg.sv - branch type encodings and 2-bit counter constants
package branch_predict_resolve_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  localparam logic [1:0] CTR_SN = 2'b00;
  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SN) ? CTR_SN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition evaluation
module branch_compare
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            valid,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    if (valid) begin
      case (branch_type)
        BEQ:     taken = (op1 == op2);
        BNE:     taken = (op1 != op2);
        BLT:     taken = ($signed(op1) <  $signed(op2));
        BGE:     taken = ($signed(op1) >= $signed(op2));
        BLTU:    taken = (op1 <  op2);
        BGEU:    taken = (op1 >= op2);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - direct-mapped BHT/BTB lookup plus EX-stage branch resolution
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            CPU_CLK,
  input  logic            CPU_RST,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic [2:0]      BranchTypeE,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] BrTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            BranchE,
  output logic            MispredictE,
  output logic [XLEN-1:0] CorrectPCE,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MispredCnt
);

  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [BHT_ENTRIES-1:0] vld_q;
  logic [TAGW-1:0]        tag_q    [BHT_ENTRIES];
  logic [XLEN-1:0]        target_q [BHT_ENTRIES];
  logic [1:0]             ctr_q    [BHT_ENTRIES];

  logic [IDXW-1:0] f_idx, e_idx;
  logic [TAGW-1:0] f_tag, e_tag;
  logic            f_hit, e_hit, upd;
  logic            unused_pcf_lsb;

  assign unused_pcf_lsb = ^PCF[1:0];

  // Fetch-side lookup reads registered state only, so a same-cycle update is not bypassed.
  assign f_idx       = PCF[IDXW+1:2];
  assign f_tag       = PCF[XLEN-1:IDXW+2];
  assign f_hit       = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = f_hit && ctr_q[f_idx][1];
  assign PredTargetF = f_hit ? target_q[f_idx] : PCF + XLEN'(4);

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .valid       (ValidE),
    .branch_type (BranchTypeE),
    .op1         (Operand1),
    .op2         (Operand2),
    .taken       (BranchE)
  );

  assign e_idx       = PCE[IDXW+1:2];
  assign e_tag       = PCE[XLEN-1:IDXW+2];
  assign e_hit       = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign upd         = ValidE && (BranchTypeE != NOBRANCH);
  assign MispredictE = upd && ((BranchE != PredTakenE) ||
                               (BranchE && (PredTargetE != BrTargetE)));
  assign CorrectPCE  = BranchE ? BrTargetE : PCE + XLEN'(4);

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      vld_q      <= '0;
      BranchCnt  <= '0;
      MispredCnt <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WN;
      end
    end else if (upd) begin
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_step(ctr_q[e_idx], BranchE);
        if (BranchE) target_q[e_idx] <= BrTargetE;
      end else if (BranchE) begin
        vld_q[e_idx]    <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= BrTargetE;
        ctr_q[e_idx]    <= CTR_WT;
      end
      if (BranchCnt != '1) BranchCnt <= BranchCnt + 32'd1;
      if (MispredictE && (MispredCnt != '1)) MispredCnt <= MispredCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - vector table and scoreboard bench for branch_predict_resolve
module tb_branch_predict_resolve;

  logic        clk, rst;
  logic [31:0] pcf, op1, op2, pce, brt, ptg, pred_target_f, correct_pc;
  logic        pred_taken_f, valid_e, ptk, branch_e, mispredict_e;
  logic [2:0]  btype;
  logic [31:0] branch_cnt, mispred_cnt;

  branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(64)) dut (
    .CPU_CLK     (clk),
    .CPU_RST     (rst),
    .PCF         (pcf),
    .PredTakenF  (pred_taken_f),
    .PredTargetF (pred_target_f),
    .ValidE      (valid_e),
    .BranchTypeE (btype),
    .Operand1    (op1),
    .Operand2    (op2),
    .PCE         (pce),
    .BrTargetE   (brt),
    .PredTakenE  (ptk),
    .PredTargetE (ptg),
    .BranchE     (branch_e),
    .MispredictE (mispredict_e),
    .CorrectPCE  (correct_pc),
    .BranchCnt   (branch_cnt),
    .MispredCnt  (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  bt;
    logic [31:0] a, b, pc, tgt;
    logic        pt;
    logic [31:0] pg;
    logic        v;
    logic        e_br, e_mis;
    logic [31:0] e_cpc;
  } vec_t;

  typedef struct {
    string       name;
    logic        br, mis, ptf;
    logic [31:0] cpc, ptgt;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  int   bcnt_m = 0, mcnt_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one EX/F cycle, queue its expectations, compare mid-cycle, then let the edge commit it.
  task automatic step(input string name, input logic [2:0] bt, input logic [31:0] a, b, pc, tgt,
                      input logic pt, input logic [31:0] pg, input logic v, input logic [31:0] f_pc,
                      input logic e_br, e_mis, input logic [31:0] e_cpc,
                      input logic e_ptf, input logic [31:0] e_ptgt);
    exp_t e;
    btype = bt; op1 = a; op2 = b; pce = pc; brt = tgt; ptk = pt; ptg = pg; valid_e = v; pcf = f_pc;
    e.name = name; e.br = e_br; e.mis = e_mis; e.cpc = e_cpc; e.ptf = e_ptf; e.ptgt = e_ptgt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, ".BranchE"},     32'(branch_e),     32'(e.br));
    chk({e.name, ".MispredictE"}, 32'(mispredict_e), 32'(e.mis));
    chk({e.name, ".CorrectPCE"},  correct_pc,        e.cpc);
    chk({e.name, ".PredTakenF"},  32'(pred_taken_f), 32'(e.ptf));
    chk({e.name, ".PredTargetF"}, pred_target_f,     e.ptgt);
    @(posedge clk);
    #1;
    if (v && bt != 3'd0) begin
      bcnt_m++;
      if (e_mis) mcnt_m++;
    end
  endtask

  task automatic idle(input string name, input logic [31:0] f_pc, input logic e_ptf,
                      input logic [31:0] e_ptgt);
    step(name, 3'd0, 0, 0, 32'h200, 0, 1'b0, 0, 1'b0, f_pc, 1'b0, 1'b0, 32'h204, e_ptf, e_ptgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pcf = 32'h100; valid_e = 1'b0; btype = 3'd0; op1 = 0; op2 = 0;
    pce = 0; brt = 0; ptk = 1'b0; ptg = 0;

    // bt, a, b, pc, tgt, pt, pg, v, e_br, e_mis, e_cpc
    vecs[0]  = '{3'd3, 32'hFFFFFFFF, 32'h1, 32'h1004, 32'h2000, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h2000};
    vecs[1]  = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h1008, 32'h2000, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h100C};
    vecs[2]  = '{3'd1, 32'h5,        32'h5, 32'h100C, 32'h2100, 1'b1, 32'h2100, 1'b1, 1'b1, 1'b0, 32'h2100};
    vecs[3]  = '{3'd1, 32'h5,        32'h6, 32'h1010, 32'h2100, 1'b1, 32'h2100, 1'b1, 1'b0, 1'b1, 32'h1014};
    vecs[4]  = '{3'd2, 32'h5,        32'h6, 32'h1014, 32'h2200, 1'b1, 32'h2204, 1'b1, 1'b1, 1'b1, 32'h2200};
    vecs[5]  = '{3'd5, 32'h80000000, 32'h0, 32'h1018, 32'h2300, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h101C};
    vecs[6]  = '{3'd6, 32'h80000000, 32'h0, 32'h101C, 32'h2300, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h2300};
    vecs[7]  = '{3'd5, 32'h3,        32'h3, 32'h1020, 32'h2400, 1'b1, 32'h2400, 1'b1, 1'b1, 1'b0, 32'h2400};
    vecs[8]  = '{3'd0, 32'h3,        32'h3, 32'h1024, 32'h2400, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h1028};
    vecs[9]  = '{3'd7, 32'h3,        32'h3, 32'h1028, 32'h2400, 1'b1, 32'h2400, 1'b1, 1'b0, 1'b1, 32'h102C};
    vecs[10] = '{3'd1, 32'h3,        32'h3, 32'h102C, 32'h2400, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h1030};
    vecs[11] = '{3'd2, 32'h7,        32'h7, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};

    #3;
    chk("reset.PredTakenF",  32'(pred_taken_f), 32'h0);
    chk("reset.PredTargetF", pred_target_f,     32'h104);
    chk("reset.BranchCnt",   branch_cnt,        32'h0);
    chk("reset.MispredCnt",  mispred_cnt,       32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      step($sformatf("vec%0d", i), vecs[i].bt, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].tgt,
           vecs[i].pt, vecs[i].pg, vecs[i].v, 32'h100,
           vecs[i].e_br, vecs[i].e_mis, vecs[i].e_cpc, 1'b0, 32'h104);
    chk("vec.BranchCnt",  branch_cnt,  32'(bcnt_m));
    chk("vec.MispredCnt", mispred_cnt, 32'(mcnt_m));

    // Cold taken branch, looked up in the same cycle it trains.
    step("cold", 3'd1, 5, 5, 32'h200, 32'h240, 1'b0, 0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h240, 1'b0, 32'h204);
    idle("trained", 32'h200, 1'b1, 32'h240);
    for (int i = 0; i < 5; i++)
      step($sformatf("nt%0d", i), 3'd1, 1, 2, 32'h200, 32'h240, 1'b0, 0, 1'b1, 32'h200,
           1'b0, 1'b0, 32'h204, (i == 0), 32'h240);
    idle("at_sn", 32'h200, 1'b0, 32'h240);
    step("tk_from_sn", 3'd1, 5, 5, 32'h200, 32'h280, 1'b0, 0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h280, 1'b0, 32'h240);
    step("tk_from_wn", 3'd1, 5, 5, 32'h200, 32'h280, 1'b0, 0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h280, 1'b0, 32'h280);
    idle("at_wt", 32'h200, 1'b1, 32'h280);
    chk("seq.BranchCnt",  branch_cnt,  32'(bcnt_m));
    chk("seq.MispredCnt", mispred_cnt, 32'(mcnt_m));

    step("invalid", 3'd1, 5, 5, 32'h200, 32'h300, 1'b0, 0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h204, 1'b1, 32'h280);
    idle("after_invalid", 32'h200, 1'b1, 32'h280);
    chk("invalid.BranchCnt",  branch_cnt,  32'(bcnt_m));
    chk("invalid.MispredCnt", mispred_cnt, 32'(mcnt_m));

    // Asynchronous reset between edges, held across an edge carrying a taken update.
    pcf = 32'h200; valid_e = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.PredTakenF",  32'(pred_taken_f), 32'h0);
    chk("midrst.PredTargetF", pred_target_f,     32'h204);
    chk("midrst.BranchCnt",   branch_cnt,        32'h0);
    chk("midrst.MispredCnt",  mispred_cnt,       32'h0);
    btype = 3'd1; op1 = 5; op2 = 5; pce = 32'h300; brt = 32'h340; valid_e = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_e = 1'b0; pcf = 32'h300;
    #1;
    chk("rstedge.PredTakenF",  32'(pred_taken_f), 32'h0);
    chk("rstedge.PredTargetF", pred_target_f,     32'h304);
    chk("rstedge.BranchCnt",   branch_cnt,        32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
